pc_unit: RTL and testbench

Parametrised program counter for the CPU datapath, replacing the fixed 32-bit increment/load PC. Adds reset vector, relative branch, stall, a fixed priority between simultaneous commands, and an optional hardware return-address stack (RAS) for call/return. Sits between the control unit, which drives the commands, and the memory address path, which consumes `pc_out`.

---
 rtl/pc_unit.sv | 112 +++++++++++
 tb/tb_pc_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter with reset vector, relative branch,
// stall, fixed command priority and an optional return-address stack (RAS).
//
// Build option: define PC_RAS_EN to build the RAS. Without it, call acts as
// load, ret is ignored and the RAS status outputs are tied off.
//
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   enable     advance enable (0 = stall, all state holds)
//   inc_pc     PC <- PC + STEP
//   branch     PC <- PC + STEP + sext(offset)
//   load       PC <- pc_in
//   call       push PC + STEP, PC <- pc_in
//   ret        pop, PC <- popped value
//   pc_in      absolute target
//   offset     signed relative offset
//   pc_out     registered PC
//   ras_empty  RAS holds no entries
//   ras_full   RAS holds DEPTH entries
//   ras_err    sticky overflow/underflow flag
module pc_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STEP      = 1,
    parameter int unsigned OFFW      = 19,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned DEPTH     = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             enable,
    input  logic             inc_pc,
    input  logic             branch,
    input  logic             load,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [OFFW-1:0]  offset,
    output logic [WIDTH-1:0] pc_out,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, ret_pc;
    logic             ret_hit;

    assign pc_inc = pc_q + WIDTH'(STEP);
    assign pc_out = pc_q;

    // ret outranks branch/inc_pc; an underflowing ret still wins and holds PC
    always_comb begin
        pc_d = load | call ? pc_in :
               ret_hit     ? ret_pc :
               branch      ? pc_inc + WIDTH'($signed(offset)) :
               inc_pc      ? pc_inc : pc_q;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            pc_q <= RESET_VEC;
        else if (enable)
            pc_q <= pc_d;
    end

`ifdef PC_RAS_EN
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] ras_q [DEPTH];
    logic [PW-1:0]    top_q, top_nx;
    logic [CW-1:0]    cnt_q;
    logic             err_q, do_call;

    assign top_nx    = top_q + PW'(1);
    assign ras_empty = cnt_q == '0;
    assign ras_full  = cnt_q == CW'(DEPTH);
    assign ras_err   = err_q;
    assign do_call   = call & ~load;
    assign ret_hit   = ret & ~load & ~call;
    assign ret_pc    = ras_empty ? pc_q : ras_q[top_q];

    // Circular buffer: a push when full lands on the oldest entry
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) ras_q[i] <= '0;
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (enable) begin
            if (do_call) begin
                ras_q[top_nx] <= pc_inc;
                top_q         <= top_nx;
                cnt_q         <= ras_full ? cnt_q : cnt_q + CW'(1);
                err_q         <= err_q | ras_full;
            end else if (ret_hit) begin
                top_q <= ras_empty ? top_q : top_q - PW'(1);
                cnt_q <= ras_empty ? cnt_q : cnt_q - CW'(1);
                err_q <= err_q | ras_empty;
            end
        end
    end
`else
    logic unused_ras;

    assign unused_ras = ret ^ (DEPTH == 0);
    assign ret_hit    = 1'b0;
    assign ret_pc     = pc_q;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;
`endif
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (default parameters).
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        enable = 1'b1;
    logic        inc_pc = 1'b0, branch = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] pc_in = '0;
    logic [18:0] offset = '0;
    logic [31:0] pc_out;
    logic        ras_empty, ras_full, ras_err;
    int          n_vec = 0;
    int          n_err = 0;

    pc_unit dut (
        .clk(clk), .clr_n(clr_n), .enable(enable), .inc_pc(inc_pc),
        .branch(branch), .load(load), .call(call), .ret(ret),
        .pc_in(pc_in), .offset(offset), .pc_out(pc_out),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one command vector for one edge, then return inputs to idle
    task automatic cyc(input logic l, input logic c, input logic r, input logic b,
                       input logic i, input logic [31:0] pin, input logic [18:0] off);
        {load, call, ret, branch, inc_pc} = {l, c, r, b, i};
        pc_in  = pin;
        offset = off;
        @(posedge clk);
        #1;
        {load, call, ret, branch, inc_pc} = '0;
    endtask

    initial begin
        #3;
        check("reset_pc", pc_out, 32'h0);
        check("reset_empty", {31'b0, ras_empty}, 32'd1);
        check("reset_full", {31'b0, ras_full}, 32'd0);
        check("reset_err", {31'b0, ras_err}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
        check("inc3", pc_out, 32'd3);
        #2 clr_n = 1'b0;
        #1 check("async_clr", pc_out, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 32'd5, 0);
        check("load5", pc_out, 32'd5);
        enable = 1'b0;
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("stall", pc_out, 32'd5);
        enable = 1'b1;
        cyc(1, 0, 0, 0, 1, 32'h100, 0);
        check("load_over_inc", pc_out, 32'h100);
        cyc(0, 0, 0, 0, 0, 32'h55, 0);
        check("idle_hold", pc_out, 32'h100);
        cyc(1, 0, 0, 0, 0, 32'h20, 0);
        cyc(0, 0, 0, 1, 1, 0, 19'h7FFFC);
        check("branch_neg", pc_out, 32'h1D);
        cyc(0, 0, 0, 1, 0, 0, 19'h00010);
        check("branch_pos", pc_out, 32'h2E);
        cyc(1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("wrap", pc_out, 32'h0);
`ifdef PC_RAS_EN
        cyc(1, 0, 0, 0, 0, 32'h10, 0);
        cyc(0, 1, 0, 0, 0, 32'h40, 0);
        check("call1", pc_out, 32'h40);
        check("call1_empty", {31'b0, ras_empty}, 32'd0);
        cyc(0, 1, 1, 1, 0, 32'h80, 0);
        check("call2", pc_out, 32'h80);
        cyc(0, 0, 1, 1, 1, 0, 19'h100);
        check("ret1", pc_out, 32'h41);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("ret2", pc_out, 32'h11);
        check("nest_empty", {31'b0, ras_empty}, 32'd1);
        check("nest_err", {31'b0, ras_err}, 32'd0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 32'h100 + k, 0);
        check("ovf_pc", pc_out, 32'h104);
        check("ovf_full", {31'b0, ras_full}, 32'd1);
        check("ovf_err", {31'b0, ras_err}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            check("ovf_ret", pc_out, 32'h104 - k);
        end
        check("drain_empty", {31'b0, ras_empty}, 32'd1);
        cyc(0, 0, 1, 0, 1, 0, 0);
        check("udf_pc", pc_out, 32'h101);
        check("udf_err", {31'b0, ras_err}, 32'd1);
        cyc(0, 1, 0, 0, 0, 32'h200, 0);
        #2 clr_n = 1'b0;
        #1 check("clr_err", {31'b0, ras_err}, 32'd0);
        check("clr_empty", {31'b0, ras_empty}, 32'd1);
        @(negedge clk);
        clr_n = 1'b1;
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("post_rst_udf", {31'b0, ras_err}, 32'd1);
        check("post_rst_pc", pc_out, 32'h0);
`else
        cyc(0, 1, 0, 1, 0, 32'h40, 19'h4);
        check("call_as_load", pc_out, 32'h40);
        check("call_empty", {31'b0, ras_empty}, 32'd1);
        cyc(0, 0, 1, 0, 1, 0, 0);
        check("ret_ignored_inc", pc_out, 32'h41);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("ret_alone_hold", pc_out, 32'h41);
        cyc(0, 0, 1, 1, 1, 0, 19'h2);
        check("ret_ignored_br", pc_out, 32'h44);
        cyc(1, 1, 0, 0, 0, 32'h77, 0);
        check("load_call", pc_out, 32'h77);
        check("noras_empty", {31'b0, ras_empty}, 32'd1);
        check("noras_full", {31'b0, ras_full}, 32'd0);
        check("noras_err", {31'b0, ras_err}, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
